uart_rx_stop_checker: RTL
=========================

Name: uart_rx_stop_checker

Overview:
Parametrised stop-bit checker for the UART receiver. It validates one or two stop bits per frame at a prescale-relative sample point and reports a framing error with a one-cycle completion strobe. It also flags line-break frames and keeps a saturating framing-error counter. It sits between the Rx FSM/edge counter/data sampler and the Rx output stage.

Parameters:
PRESCALE_WIDTH, 5, width of Prescale and Edge_Cnt
ERR_CNT_WIDTH, 8, width of the saturating framing-error counter

Ports:
CLK  input  1  clock; reset is synchronous and active-high
RST  input  1  synchronous active-high reset
Stp_Chk_En  input  1  Rx FSM is in the stop-bit phase; held high for the whole stop field
Two_Stop  input  1  0 = one stop bit, 1 = two stop bits; sampled on IDLE->STOP1
Sampled_Bit  input  1  majority-voted line value from the data sampler
Prescale  input  PRESCALE_WIDTH  oversampling ratio
Edge_Cnt  input  PRESCALE_WIDTH  edge counter within the current bit, 0..Prescale-1
Data_Zero  input  1  the frame's data and parity bits were all 0
Err_Cnt_Clr  input  1  clear the error counter
Stp_Err  output  1  framing error for the last completed frame
Stp_Done  output  1  one-cycle strobe: stop check complete
Brk_Det  output  1  the last completed frame was a line break
Err_Cnt  output  ERR_CNT_WIDTH  saturating count of frames with Stp_Err

Behaviour:
- CHK = (Prescale >> 1) + 2, computed at PRESCALE_WIDTH+1 bits. Edge_Cnt is zero-extended for the compare. LAST = Prescale - 1.
- Legal Prescale is >= 5 (so CHK < Prescale). With an illegal value no check fires. The FSM then waits in STOP1/STOP2 with no Stp_Done until Stp_Chk_En drops.
- Reset (RST=1 at a CLK edge): state=IDLE; Stp_Err=0, Stp_Done=0, Brk_Det=0, Err_Cnt=0; internal mode and err1 registers = 0. Reset mid-frame aborts with no strobe.
- State IDLE: if Stp_Chk_En=1, go to STOP1 and latch mode<=Two_Stop. No sampling happens in the entry cycle.
- State STOP1: if Stp_Chk_En=0, go to IDLE (abort, no strobe, outputs unchanged).
  - Else, if Edge_Cnt==CHK and mode=0: Stp_Err<=~Sampled_Bit; Brk_Det<=Data_Zero & ~Sampled_Bit; Stp_Done<=1; go to HOLD.
  - Else, if Edge_Cnt==CHK and mode=1: err1<=~Sampled_Bit; brk1<=Data_Zero & ~Sampled_Bit; stay in STOP1.
  - Else, if mode=1 and Edge_Cnt==LAST: go to STOP2.
- State STOP2: if Stp_Chk_En=0, go to IDLE (abort).
  - Else, if Edge_Cnt==CHK: Stp_Err<=err1 | ~Sampled_Bit; Brk_Det<=brk1; Stp_Done<=1; go to HOLD.
- State HOLD: Stp_Done returns to 0 on the next cycle. Stay in HOLD until Stp_Chk_En=0, then go to IDLE. No second check occurs in the same stop field.
- Stp_Done is high for exactly one cycle, on the cycle after the deciding CHK edge. Stp_Err and Brk_Det are registered together with Stp_Done and hold their values until the next Stp_Done or reset.
- Err_Cnt:
  - Err_Cnt_Clr=1 sets it to 0; clear wins over a simultaneous increment.
  - Otherwise it increments by 1 on a cycle where Stp_Done is being set with the new Stp_Err=1.
  - It saturates at 2^ERR_CNT_WIDTH-1.
- A Two_Stop change after STOP1 entry has no effect on the current frame.
- An Edge_Cnt value of CHK seen in IDLE or HOLD is ignored.

Test Plan:
1. Prescale=8 (CHK=6), Two_Stop=0, Sampled_Bit=1 at Edge_Cnt=6 -> one cycle later Stp_Done=1 for 1 cycle, Stp_Err=0, Brk_Det=0, Err_Cnt=0.
2. Prescale=8, Two_Stop=0, Sampled_Bit=0 at Edge_Cnt=6, Data_Zero=1 -> Stp_Err=1, Brk_Det=1, Err_Cnt=1. The following good frame gives Stp_Err=0, Brk_Det=0, Err_Cnt=1.
3. Prescale=16 (CHK=10), Two_Stop=1: first stop bit=0, second=1 -> single Stp_Done after the second-bit CHK with Stp_Err=1. Swapped order (1 then 0) also gives Stp_Err=1. Both bits 1 gives Stp_Err=0. No strobe after the first bit in any case.
4. Abort: Stp_Chk_En drops in STOP2 before CHK, or RST=1 mid-STOP1 -> no Stp_Done. On abort, outputs keep their prior values. On reset, all outputs are 0.
5. ERR_CNT_WIDTH=2: 5 consecutive error frames -> Err_Cnt sequence 1,2,3,3,3. Err_Cnt_Clr asserted on the same cycle as an error strobe -> Err_Cnt=0.
6. Prescale=4 (illegal, CHK=4) with Stp_Chk_En held for 8 cycles -> no Stp_Done. Dropping the enable returns the FSM to IDLE, and the next legal frame checks normally.

Source files
------------

// File: rtl/uart_rx_stop_checker_if.sv
// Stop-checker bus between the Rx FSM/edge counter/data sampler and the Rx output stage.
//   master : drives the stop-phase controls and samples, receives the check results
//   slave  : the stop-bit checker
// Signals:
//   Stp_Chk_En, Two_Stop, Sampled_Bit, Prescale, Edge_Cnt, Data_Zero, Err_Cnt_Clr -> checker
//   Stp_Err, Stp_Done, Brk_Det, Err_Cnt                                           <- checker
interface uart_rx_stop_checker_if #(
    parameter int unsigned PRESCALE_WIDTH = 5,
    parameter int unsigned ERR_CNT_WIDTH  = 8
);
    logic                      Stp_Chk_En;
    logic                      Two_Stop;
    logic                      Sampled_Bit;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic [PRESCALE_WIDTH-1:0] Edge_Cnt;
    logic                      Data_Zero;
    logic                      Err_Cnt_Clr;
    logic                      Stp_Err;
    logic                      Stp_Done;
    logic                      Brk_Det;
    logic [ERR_CNT_WIDTH-1:0]  Err_Cnt;

    modport master (
        output Stp_Chk_En, Two_Stop, Sampled_Bit, Prescale, Edge_Cnt, Data_Zero, Err_Cnt_Clr,
        input  Stp_Err, Stp_Done, Brk_Det, Err_Cnt
    );

    modport slave (
        input  Stp_Chk_En, Two_Stop, Sampled_Bit, Prescale, Edge_Cnt, Data_Zero, Err_Cnt_Clr,
        output Stp_Err, Stp_Done, Brk_Det, Err_Cnt
    );
endinterface

// File: rtl/uart_rx_stop_checker.sv
// UART Rx stop-bit checker: samples one or two stop bits at edge CHK = Prescale/2 + 2,
// reports framing error / line break with a one-cycle completion strobe, and keeps a
// saturating framing-error counter.
// Ports:
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : slave side of uart_rx_stop_checker_if (controls/samples in, results out)
module uart_rx_stop_checker #(
    parameter int unsigned PRESCALE_WIDTH = 5,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_stop_checker_if.slave  bus
);

    localparam int unsigned CW = PRESCALE_WIDTH + 1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STOP1 = 2'd1,
        ST_STOP2 = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic                      err1_q, err1_d;
    logic                      brk1_q, brk1_d;
    logic                      stp_err_q, stp_err_d;
    logic                      stp_done_q, stp_done_d;
    logic                      brk_det_q, brk_det_d;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic [CW-1:0]             chk_c;
    logic [PRESCALE_WIDTH-1:0] last_c;
    logic                      at_chk_c;
    logic                      at_last_c;

    // Sample point and last edge of a bit; one extra bit keeps CHK exact for large Prescale
    assign chk_c     = CW'(bus.Prescale >> 1) + CW'(2);
    assign last_c    = bus.Prescale - PRESCALE_WIDTH'(1);
    assign at_chk_c  = (CW'(bus.Edge_Cnt) == chk_c);
    assign at_last_c = (bus.Edge_Cnt == last_c);

    // Next-state and result logic
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        err1_d     = err1_q;
        brk1_d     = brk1_q;
        stp_err_d  = stp_err_q;
        stp_done_d = 1'b0;
        brk_det_d  = brk_det_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Stp_Chk_En) begin
                    state_d = ST_STOP1;
                    mode_d  = bus.Two_Stop;
                end
            end
            ST_STOP1: begin
                if (!bus.Stp_Chk_En) begin
                    state_d = ST_IDLE;
                end else if (at_chk_c && !mode_q) begin
                    stp_err_d  = ~bus.Sampled_Bit;
                    brk_det_d  = bus.Data_Zero & ~bus.Sampled_Bit;
                    stp_done_d = 1'b1;
                    state_d    = ST_HOLD;
                end else if (at_chk_c && mode_q) begin
                    err1_d = ~bus.Sampled_Bit;
                    brk1_d = bus.Data_Zero & ~bus.Sampled_Bit;
                end else if (mode_q && at_last_c) begin
                    // CHK has priority, so a Prescale with CHK == LAST never reaches STOP2
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (!bus.Stp_Chk_En) begin
                    state_d = ST_IDLE;
                end else if (at_chk_c) begin
                    stp_err_d  = err1_q | ~bus.Sampled_Bit;
                    brk_det_d  = brk1_q;
                    stp_done_d = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!bus.Stp_Chk_En) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear beats a same-cycle increment; count saturates at all-ones
        if (bus.Err_Cnt_Clr) begin
            err_cnt_d = '0;
        end else if (stp_done_d && stp_err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            err1_q     <= 1'b0;
            brk1_q     <= 1'b0;
            stp_err_q  <= 1'b0;
            stp_done_q <= 1'b0;
            brk_det_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            err1_q     <= err1_d;
            brk1_q     <= brk1_d;
            stp_err_q  <= stp_err_d;
            stp_done_q <= stp_done_d;
            brk_det_q  <= brk_det_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.Stp_Err  = stp_err_q;
    assign bus.Stp_Done = stp_done_q;
    assign bus.Brk_Det  = brk_det_q;
    assign bus.Err_Cnt  = err_cnt_q;

endmodule
